// File: rtl/msk_sync_sched.sv
// -----------------------------------------------------------------------------
// msk_sync_sched
//
// Bit-strobe scheduler for the MSK demodulator output stage. Raw one-cycle
// timing pulses from the bit-timing recovery loop are gated against an
// expected-period window and turned into alternating I/Q sampling strobes.
// Missing pulses are filled in by a flywheel while locked, and a
// SEARCH/VERIFY/LOCK state machine decides when pulses are trusted.
//
// Ports
//   clk        in   system clock, single domain
//   rst        in   asynchronous active-low reset
//   en         in   clock enable; low freezes all state and suppresses strobes
//   ted_pulse  in   one-cycle timing pulse, one per bit
//   flip       in   one-cycle request to swap the I/Q branch assignment
//   Isync      out  one-cycle I-branch strobe (registered)
//   Qsync      out  one-cycle Q-branch strobe (registered)
//   locked     out  high while in LOCK
//   state      out  00 SEARCH, 01 VERIFY, 10 LOCK
//   ins_cnt    out  saturating count of flywheel insertions
//
// Input/output protocol: ted_pulse and flip are single-cycle qualifiers
// sampled on every rising clk edge where en is high; there is no back-pressure.
// A pulse accepted in cycle t produces exactly one strobe in cycle t+1.
// -----------------------------------------------------------------------------
module msk_sync_sched #(
   parameter int CW       = 8,
   parameter int NOMINAL  = 8,
   parameter int TOL      = 1,
   parameter int LOCK_CNT = 4,
   parameter int MISS_MAX = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       ted_pulse,
   input  logic       flip,
   output logic       Isync,
   output logic       Qsync,
   output logic       locked,
   output logic [1:0] state,
   output logic [7:0] ins_cnt
);

   // Counter widths sized so LOCK_CNT and MISS_MAX are representable.
   localparam int GW = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);
   localparam int MW = (MISS_MAX < 2) ? 1 : $clog2(MISS_MAX + 1);

   localparam logic [CW-1:0] WIN_LO = CW'(NOMINAL - TOL);
   localparam logic [CW-1:0] WIN_HI = CW'(NOMINAL + TOL);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);
   localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
   localparam logic [GW-1:0] GOOD_ONE = GW'(1);
   localparam logic [GW-1:0] GOOD_TGT = GW'(LOCK_CNT);
   localparam logic [MW-1:0] MISS_ONE = MW'(1);
   localparam logic [MW-1:0] MISS_LIM = MW'(MISS_MAX);

   typedef enum logic [1:0] {
      S_SEARCH = 2'b00,
      S_VERIFY = 2'b01,
      S_LOCK   = 2'b10
   } state_t;

   state_t          st;
   logic [CW-1:0]   cnt;       // clocks elapsed since the last strobe
   logic            br;        // 0: next strobe is I, 1: next strobe is Q
   logic [GW-1:0]   good;      // in-window pulses seen in VERIFY
   logic [MW-1:0]   miss_run;  // consecutive flywheel insertions in LOCK

   // Decision signals for the current cycle (before the en gate).
   logic            in_win;
   logic            at_hi;
   logic            accept;
   logic            timeout;
   logic            insert;
   logic            drop;
   logic            strobe;
   logic            sel;
   logic [GW-1:0]   good_inc;

   assign state = st;

   always_comb begin
      in_win   = (cnt >= WIN_LO) && (cnt <= WIN_HI);
      at_hi    = (cnt == WIN_HI);
      good_inc = good + GOOD_ONE;
      accept   = 1'b0;
      timeout  = 1'b0;
      insert   = 1'b0;
      drop     = 1'b0;

      case (st)
         S_SEARCH: begin
            // Any pulse restarts the acquisition attempt.
            accept = ted_pulse;
         end
         S_VERIFY, S_LOCK: begin
            // Early pulses fall outside the window and are simply ignored.
            // A pulse exactly at the upper window edge wins over timeout.
            accept  = ted_pulse && in_win;
            timeout = !ted_pulse && at_hi;
         end
         default: begin
            accept = 1'b0;
         end
      endcase

      if (timeout) begin
         if ((st == S_LOCK) && (miss_run < MISS_LIM)) begin
            insert = 1'b1;
         end else begin
            drop = 1'b1;
         end
      end

      strobe = accept || insert;
      // A flip in the same cycle as a strobe already redirects that strobe.
      sel    = br ^ flip;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         st       <= S_SEARCH;
         cnt      <= '0;
         br       <= 1'b0;
         good     <= '0;
         miss_run <= '0;
         ins_cnt  <= 8'd0;
         Isync    <= 1'b0;
         Qsync    <= 1'b0;
         locked   <= 1'b0;
      end else if (!en) begin
         // Everything holds; only the strobe outputs are forced idle so a
         // stalled cycle never repeats or stretches a strobe.
         Isync <= 1'b0;
         Qsync <= 1'b0;
      end else begin
         Isync <= strobe && !sel;
         Qsync <= strobe && sel;

         if (strobe) begin
            cnt <= CNT_ONE;
            br  <= ~sel;
         end else begin
            if (cnt != CNT_MAX) begin
               cnt <= cnt + CNT_ONE;
            end
            // Without a strobe, flip just toggles the pending branch.
            br <= br ^ flip;
         end

         case (st)
            S_SEARCH: begin
               if (accept) begin
                  st     <= S_VERIFY;
                  good   <= '0;
                  locked <= 1'b0;
               end
            end

            S_VERIFY: begin
               if (accept) begin
                  good <= good_inc;
                  if (good_inc == GOOD_TGT) begin
                     st       <= S_LOCK;
                     locked   <= 1'b1;
                     miss_run <= '0;
                  end
               end else if (drop) begin
                  st       <= S_SEARCH;
                  locked   <= 1'b0;
                  ins_cnt  <= 8'd0;
                  miss_run <= '0;
               end
            end

            S_LOCK: begin
               if (accept) begin
                  miss_run <= '0;
               end else if (insert) begin
                  miss_run <= miss_run + MISS_ONE;
                  if (ins_cnt != 8'hFF) begin
                     ins_cnt <= ins_cnt + 8'd1;
                  end
               end else if (drop) begin
                  st       <= S_SEARCH;
                  locked   <= 1'b0;
                  ins_cnt  <= 8'd0;
                  miss_run <= '0;
               end
            end

            default: begin
               // Unused encoding: recover to SEARCH with a clean slate.
               st       <= S_SEARCH;
               locked   <= 1'b0;
               ins_cnt  <= 8'd0;
               miss_run <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_msk_sync_sched.sv
// -----------------------------------------------------------------------------
// tb_msk_sync_sched
//
// Directed-plus-random bench for msk_sync_sched. A behavioural model tracks
// "clocks since last strobe", the acquisition mode and the pending branch, and
// predicts every output cycle by cycle.
// -----------------------------------------------------------------------------
module tb_msk_sync_sched;

   localparam int NOM   = 8;
   localparam int TOLV  = 1;
   localparam int LOCKN = 4;
   localparam int MISSN = 3;
   localparam int LO    = NOM - TOLV;
   localparam int HI    = NOM + TOLV;

   // ---------------- clock / reset / DUT ----------------
   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic       ted_pulse;
   logic       flip;
   logic       Isync;
   logic       Qsync;
   logic       locked;
   logic [1:0] state;
   logic [7:0] ins_cnt;

   always #5 clk = ~clk;

   msk_sync_sched #(
      .CW(8), .NOMINAL(NOM), .TOL(TOLV), .LOCK_CNT(LOCKN), .MISS_MAX(MISSN)
   ) dut (
      .clk(clk), .rst(rst), .en(en), .ted_pulse(ted_pulse), .flip(flip),
      .Isync(Isync), .Qsync(Qsync), .locked(locked), .state(state),
      .ins_cnt(ins_cnt)
   );

   // ---------------- scoreboard / model ----------------
   int n_checks = 0;
   int n_pass   = 0;

   int m_since;     // clocks since last strobe (saturates at 255)
   int m_mode;      // 0 searching, 1 verifying, 2 locked
   int m_good;
   int m_miss;
   int m_ins;
   bit m_next_q;
   bit e_i;
   bit e_q;
   logic [0:0] exp_q[$];   // branch of each strobe the model has issued

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
   endtask

   function automatic void model_reset();
      m_since  = 0;
      m_mode   = 0;
      m_good   = 0;
      m_miss   = 0;
      m_ins    = 0;
      m_next_q = 1'b0;
      e_i      = 1'b0;
      e_q      = 1'b0;
      exp_q.delete();
   endfunction

   // One enabled cycle, stated in terms of the scheduling rules.
   function automatic void model_step(input bit p, input bit f);
      bit fire;
      bit inwin;
      bit q;
      fire  = 1'b0;
      inwin = (m_since >= LO) && (m_since <= HI);
      if (m_mode == 0) begin
         if (p) begin
            fire   = 1'b1;
            m_mode = 1;
            m_good = 0;
         end
      end else if (p && inwin) begin
         fire = 1'b1;
         if (m_mode == 1) begin
            m_good++;
            if (m_good >= LOCKN) begin
               m_mode = 2;
               m_miss = 0;
            end
         end else begin
            m_miss = 0;
         end
      end else if (!p && m_since == HI) begin
         if (m_mode == 2 && m_miss < MISSN) begin
            fire = 1'b1;
            m_miss++;
            if (m_ins < 255) m_ins++;
         end else begin
            m_mode = 0;
            m_ins  = 0;
            m_miss = 0;
         end
      end
      q = m_next_q ^ f;
      if (fire) begin
         e_i      = !q;
         e_q      = q;
         m_next_q = !q;
         m_since  = 1;
         exp_q.push_back(q);
      end else begin
         e_i = 1'b0;
         e_q = 1'b0;
         if (f) m_next_q = !m_next_q;
         if (m_since < 255) m_since++;
      end
   endfunction

   task automatic compare_outputs();
      logic [0:0] b;
      check("isync", Isync, e_i);
      check("qsync", Qsync, e_q);
      check("mutex", Isync & Qsync, 0);
      check("state", state, m_mode);
      check("locked", locked, (m_mode == 2));
      check("ins_cnt", ins_cnt, m_ins);
      if (exp_q.size() > 0) begin
         b = exp_q.pop_front();
         check("strobe_branch", {Isync, Qsync}, (b == 1'b1) ? 2'b01 : 2'b10);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick(input bit p, input bit f, input bit e);
      ted_pulse = p;
      flip      = f;
      en        = e;
      if (!rst) begin
         model_reset();
      end else if (e) begin
         model_step(p, f);
      end else begin
         e_i = 1'b0;
         e_q = 1'b0;
      end
      @(posedge clk);
      #1;
      compare_outputs();
   endtask

   task automatic idle(input int n);
      repeat (n) tick(1'b0, 1'b0, 1'b1);
   endtask

   // Pulse arriving when the period count is k.
   task automatic gap(input int k, input bit f_end);
      idle(k - 1);
      tick(1'b1, f_end, 1'b1);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int k;
      rst       = 1'b0;
      en        = 1'b0;
      ted_pulse = 1'b0;
      flip      = 1'b0;
      model_reset();

      // Reset state before any clock edge, then held through a few edges.
      #3;
      compare_outputs();
      repeat (3) tick(1'b1, 1'b1, 1'b1);
      rst = 1'b1;

      // Lock acquisition with ideal 8-clock pulses.
      idle(3);
      tick(1'b1, 1'b0, 1'b1);
      repeat (5) gap(8, 1'b0);

      // Single flywheel insertion, then recovery.
      idle(9);
      gap(8, 1'b0);
      gap(8, 1'b0);

      // Jitter window: 7 and 9 accepted, 5 ignored and followed by insertion.
      gap(7, 1'b0);
      gap(9, 1'b0);
      gap(5, 1'b0);
      idle(4);
      gap(8, 1'b0);
      gap(8, 1'b0);

      // Flip alone between strobes, then flip coincident with a pulse.
      idle(2);
      tick(1'b0, 1'b1, 1'b1);
      idle(4);
      tick(1'b1, 1'b0, 1'b1);
      gap(8, 1'b1);
      gap(8, 1'b0);
      gap(8, 1'b0);

      // Enable low: random pulses/flips must be ignored, count frozen.
      idle(3);
      repeat ($urandom_range(5, 15)) tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
      idle(3);
      tick(1'b1, 1'b0, 1'b1);
      gap(8, 1'b0);

      // Loss of lock: three insertions, then back to searching.
      idle(40);

      // VERIFY failure: missing pulse at the upper edge.
      tick(1'b1, 1'b0, 1'b1);
      gap(8, 1'b0);
      idle(12);

      // Randomized traffic: jittered periods, dropped pulses, flips, stalls.
      repeat (40) begin
         k = $urandom_range(5, 11);
         for (int j = 1; j < k; j++)
            tick(1'b0, 1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 15) != 0));
         tick(1'($urandom_range(0, 5) != 0), 1'($urandom_range(0, 7) == 0), 1'b1);
      end

      // Reacquire, then reset asynchronously in the middle of a cycle.
      idle(2);
      tick(1'b1, 1'b0, 1'b1);
      repeat (6) gap(8, 1'b0);
      gap(8, 1'b0);
      #2;
      rst = 1'b0;
      #1;
      model_reset();
      compare_outputs();
      repeat (2) tick(1'b1, 1'b0, 1'b1);
      rst = 1'b1;
      tick(1'b1, 1'b0, 1'b1);
      gap(8, 1'b0);
      idle(2);

      check("exp_q_drained", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
